// File: rtl/dispense_ctrl.sv
// dispense_ctrl: product dispense sequencer.
// A valid request latches the product code, drives the motor for PULSE_LEN
// cycles, then waits up to TIMEOUT cycles for the motor-done sensor. On success
// it issues a one-cycle completion strobe carrying the code. On timeout it
// holds an error until it is cleared. Invalid codes raise a one-cycle error.
// Optional feature: define DISPENSE_COUNT_EN to add a saturating 8-bit count
// (cnt) of completed dispenses.
module dispense_ctrl #(
    parameter int PW        = 3,
    parameter int NPROD     = 5,
    parameter int PULSE_LEN = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [PW-1:0] C,
    input  logic          K,
    input  logic          ack,
    input  logic          clr,
    output logic          motor,
    output logic          busy,
    output logic          A,
    output logic [PW-1:0] P,
    output logic          err
`ifdef DISPENSE_COUNT_EN
    ,
    output logic [7:0]    cnt
`endif
);

    // One counter serves both the drive pulse and the ack timeout, so it is
    // sized for the larger of the two; its terminal values stop it before wrap.
    localparam int            MAXC       = (PULSE_LEN > TIMEOUT) ? PULSE_LEN : TIMEOUT;
    localparam int            CW         = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DRIVE_LAST = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] CODE_MAX   = PW'(NPROD);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT_ACK,
        DONE,
        FAULT
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] count_reg, count_next;
    logic [PW-1:0] code_reg, code_next;
    logic          bad_req;
    logic          motor_next, busy_next, a_next, err_next;
    logic [PW-1:0] p_next;

    // Next-state, counter and latched-code logic; outputs are derived from
    // the next state so the registered outputs line up with the state.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        code_next  = code_reg;
        bad_req    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (K) begin
                    if ((C != '0) && (C <= CODE_MAX)) begin
                        state_next = DRIVE;
                        code_next  = C;
                        count_next = '0;
                    end else begin
                        bad_req = 1'b1;
                    end
                end
            end
            DRIVE: begin
                // ack is deliberately not looked at while the motor runs
                if (count_reg == DRIVE_LAST) begin
                    state_next = WAIT_ACK;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            WAIT_ACK: begin
                // ack takes priority, so an ack on the last allowed cycle succeeds
                if (ack) begin
                    state_next = DONE;
                    count_next = '0;
                end else if (count_reg == WAIT_LAST) begin
                    state_next = FAULT;
                    count_next = '0;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            FAULT: begin
                if (clr) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        motor_next = (state_next == DRIVE);
        busy_next  = (state_next != IDLE);
        a_next     = (state_next == DONE);
        p_next     = (state_next == DONE) ? code_next : '0;
        err_next   = (state_next == FAULT) || bad_req;
    end

    // State, counter, latched code and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            code_reg  <= '0;
            motor     <= 1'b0;
            busy      <= 1'b0;
            A         <= 1'b0;
            P         <= '0;
            err       <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            code_reg  <= code_next;
            motor     <= motor_next;
            busy      <= busy_next;
            A         <= a_next;
            P         <= p_next;
            err       <= err_next;
        end
    end

`ifdef DISPENSE_COUNT_EN
    // Saturating count of completed dispenses, bumped once per DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= 8'd0;
        end else if ((state_reg == DONE) && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dispense_ctrl.sv
// tb_dispense_ctrl: directed bench for dispense_ctrl with a time-based
// behavioural model (phases derived from cycles elapsed since acceptance),
// a per-cycle compare process and hand-computed literal expectations.
module tb_dispense_ctrl;

    localparam int PW = 3;
    localparam int NP = 5;
    localparam int PL = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [PW-1:0] C = '0;
    logic          K = 1'b0;
    logic          ack = 1'b0;
    logic          clr = 1'b0;
    logic          motor, busy, A, err;
    logic [PW-1:0] P;
`ifdef DISPENSE_COUNT_EN
    logic [7:0]    cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    dispense_ctrl #(.PW(PW), .NPROD(NP), .PULSE_LEN(PL), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .C     (C),
        .K     (K),
        .ack   (ack),
        .clr   (clr),
        .motor (motor),
        .busy  (busy),
        .A     (A),
        .P     (P),
        .err   (err)
`ifdef DISPENSE_COUNT_EN
        ,
        .cnt   (cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A transaction is described by its acceptance cycle; the motor window and
    // the ack window follow from the elapsed cycle count.
    int cyc = 0;
    int t_acc = 0;
    int m_code = 0;
    int m_cnt = 0;
    bit m_act = 1'b0, m_done = 1'b0, m_fault = 1'b0, m_errp = 1'b0;

    always @(posedge clk or posedge reset) begin
        int el;
        if (reset) begin
            m_act = 0; m_done = 0; m_fault = 0; m_errp = 0; m_code = 0; m_cnt = 0;
        end else begin
            cyc++;
            m_errp = 0;
            if (m_done) begin
                m_done = 0;
                if (m_cnt < 255) m_cnt++;
            end else if (m_fault) begin
                if (clr) m_fault = 0;
            end else if (m_act) begin
                el = cyc - t_acc;
                if (el > PL) begin
                    if (ack) begin
                        m_act = 0; m_done = 1;
                    end else if (el - PL == TO) begin
                        m_act = 0; m_fault = 1;
                    end
                end
            end else if (K) begin
                if (int'(C) >= 1 && int'(C) <= NP) begin
                    m_act = 1; t_acc = cyc; m_code = int'(C);
                end else begin
                    m_errp = 1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("motor", int'(motor), int'(m_act && ((cyc - t_acc) < PL)));
            check("busy", int'(busy), int'(m_act || m_done || m_fault));
            check("A", int'(A), int'(m_done));
            check("P", int'(P), m_done ? m_code : 0);
            check("err", int'(err), int'(m_fault || m_errp));
`ifdef DISPENSE_COUNT_EN
            check("cnt", int'(cnt), m_cnt);
`endif
        end
    end

    // Event tallies used by the literal checks (sampled at idle points only).
    int n_motor = 0, n_a = 0, n_err = 0;
    always @(negedge clk) begin
        if (motor) n_motor++;
        if (A) n_a++;
        if (err) n_err++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    int s_motor, s_a, s_err;
    task automatic snap();
        s_motor = n_motor; s_a = n_a; s_err = n_err;
    endtask

    initial begin
        #3 reset = 1'b1;
        #1;
        chk_en = 1'b1;
        check("rst_motor", int'(motor), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_A", int'(A), 0);
        check("rst_P", int'(P), 0);
        check("rst_err", int'(err), 0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Basic dispense: code 3, ack two cycles after motor falls
        snap();
        C = 3; K = 1;
        tick(1); K = 0;
        check("drv_motor_on", int'(motor), 1);
        tick(4);
        check("drv_motor_off", int'(motor), 0);
        tick(1); ack = 1;
        tick(1); ack = 0;
        check("lat_A", int'(A), 1);
        check("lat_P", int'(P), 3);
        tick(1);
        check("post_busy", int'(busy), 0);
        tick(1);
        check("motor_cycles", n_motor - s_motor, 4);
        check("a_pulses", n_a - s_a, 1);
        $display("txn basic code=3 done");

        // Invalid code above range
        snap();
        C = 6; K = 1;
        tick(1); K = 0;
        check("bad6_err", int'(err), 1);
        check("bad6_busy", int'(busy), 0);
        tick(1);
        check("bad6_err_clear", int'(err), 0);
        tick(1);
        check("bad6_err_cycles", n_err - s_err, 1);
        check("bad6_no_motor", n_motor - s_motor, 0);
        $display("txn invalid code=6 done");

        // Invalid code zero, with clr wiggled in IDLE (must have no effect)
        C = 0; K = 1; clr = 1;
        tick(1); K = 0; clr = 0;
        check("bad0_err", int'(err), 1);
        tick(2);
        $display("txn invalid code=0 done");

        // Timeout into FAULT, then clear
        C = 2; K = 1;
        tick(1); K = 0;
        tick(18);
        check("to_before_err", int'(err), 0);
        check("to_before_busy", int'(busy), 1);
        tick(1);
        check("to_fault_err", int'(err), 1);
        tick(5);
        check("to_err_held", int'(err), 1);
        check("to_motor_off", int'(motor), 0);
        clr = 1;
        tick(1); clr = 0;
        check("clr_err", int'(err), 0);
        check("clr_busy", int'(busy), 0);
        tick(1);
        $display("txn timeout code=2 done");

        // Code 5 accepted; code change, K pulse, clr and early ack during DRIVE
        snap();
        C = 5; K = 1;
        tick(1); K = 0;
        tick(1); C = 1; K = 1; clr = 1; ack = 1;
        tick(1); K = 0; clr = 0;
        tick(3);
        check("chg_A", int'(A), 1);
        check("chg_P", int'(P), 5);
        ack = 0;
        tick(3);
        check("chg_a_pulses", n_a - s_a, 1);
        $display("txn code=5 with changes done");

        // Ack on the final timeout cycle wins
        C = 1; K = 1;
        tick(1); K = 0;
        tick(18); ack = 1;
        tick(1); ack = 0;
        check("last_A", int'(A), 1);
        check("last_P", int'(P), 1);
        check("last_err", int'(err), 0);
        tick(2);
        $display("txn ack on last timeout cycle done");

        // K held high across a whole transaction: re-accepted after IDLE
        C = 4; K = 1; ack = 1;
        tick(6);
        check("hold_A", int'(A), 1);
        tick(1);
        check("hold_idle_motor", int'(motor), 0);
        tick(1);
        check("hold_reaccept_motor", int'(motor), 1);
        K = 0;
        tick(7); ack = 0;
        tick(2);
        $display("txn held request done");

        // Reset in the third DRIVE cycle, then immediate acceptance
        snap();
        C = 2; K = 1;
        tick(1); K = 0;
        tick(2);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_motor", int'(motor), 0);
        check("rst_mid_busy", int'(busy), 0);
        tick(1);
        reset = 1'b0; C = 1; K = 1;
        tick(1); K = 0;
        check("rst_first_accept", int'(motor), 1);
        check("rst_no_A", n_a - s_a, 0);
        ack = 1;
        tick(5); ack = 0;
        check("rst_after_A", int'(A), 1);
        tick(2);
        $display("txn reset mid-drive done");

`ifdef DISPENSE_COUNT_EN
        // Many back-to-back dispenses to saturate the counter
        C = 1; K = 1; ack = 1;
        tick(260 * 7);
        K = 0;
        tick(8); ack = 0;
        tick(2);
        check("cnt_saturate", int'(cnt), 255);
        $display("txn 260 dispenses done");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
